// File: rtl/demux_gate_pkg.sv
// demux_gate_pkg
//   Shared definitions for the demux logic engine:
//   - op_e     : operation codes (AND, OR, NOT, NAND, NOR, XOR, XNOR, BUF)
//   - state_e  : engine FSM encoding (IDLE=0, RUN=1, DONE=2; code 3 is unused)
//   - cnt_width: width of the chunk counter for a given chunk count (minimum 1)
//   - dmx      : 1:2 demultiplexer primitive used to build every logic function
package demux_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

  // Steers d to output [1] when s=1, otherwise to output [0]; the idle
  // output is held at 0. Result is {out1, out0}.
  function automatic logic [1:0] dmx(input logic d, input logic s);
    return s ? {d, 1'b0} : {1'b0, d};
  endfunction

endpackage

// File: rtl/demux_gate_slice.sv
// demux_gate_slice
//   One result bit of the logic engine, built purely from 1:2 demux steering.
//   Ports:
//     a_i  in  1  operand A bit
//     b_i  in  1  operand B bit (unused by NOT and BUF)
//     op   in  3  operation code (see demux_gate_pkg::op_e)
//     y_o  out 1  result bit
import demux_gate_pkg::*;

module demux_gate_slice (
  input  logic       a_i,
  input  logic       b_i,
  input  logic [2:0] op,
  output logic       y_o
);

  logic [1:0] d_na, d_nb, d_ab, d_nanb, d_or, d_nand;
  logic [1:0] d_anb, d_np, d_nq, d_pq, d_xor, d_buf;
  logic       na, nb, and_v, nor_v, or_v, nand_v;
  logic       p_v, q_v, np_v, nq_v, xnor_v, xor_v, buf_v;

  always_comb begin
    // Steering a constant 1 by x leaves it on the "x=0" output: that is ~x.
    d_na   = dmx(1'b1, a_i);
    na     = d_na[0];
    d_nb   = dmx(1'b1, b_i);
    nb     = d_nb[0];

    // b steered by a: out1 = a&b, out0 = ~a&b.
    d_ab   = dmx(b_i, a_i);
    and_v  = d_ab[1];
    q_v    = d_ab[0];

    d_nanb = dmx(nb, na);
    nor_v  = d_nanb[1];
    d_or   = dmx(1'b1, nor_v);
    or_v   = d_or[0];
    d_nand = dmx(1'b1, and_v);
    nand_v = d_nand[0];

    // XOR is the OR of the two disjoint terms a&~b and ~a&b, built De Morgan
    // style; the intermediate (~p & ~q) is XNOR directly.
    d_anb  = dmx(nb, a_i);
    p_v    = d_anb[1];
    d_np   = dmx(1'b1, p_v);
    np_v   = d_np[0];
    d_nq   = dmx(1'b1, q_v);
    nq_v   = d_nq[0];
    d_pq   = dmx(nq_v, np_v);
    xnor_v = d_pq[1];
    d_xor  = dmx(1'b1, xnor_v);
    xor_v  = d_xor[0];

    d_buf  = dmx(1'b1, na);
    buf_v  = d_buf[0];
  end

  always_comb begin
    y_o = 1'b0;
    case (op)
      OP_AND:  y_o = and_v;
      OP_OR:   y_o = or_v;
      OP_NOT:  y_o = na;
      OP_NAND: y_o = nand_v;
      OP_NOR:  y_o = nor_v;
      OP_XOR:  y_o = xor_v;
      OP_XNOR: y_o = xnor_v;
      OP_BUF:  y_o = buf_v;
      default: y_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/demux_logic_engine.sv
// demux_logic_engine
//   Serialised bitwise logic unit: evaluates one of eight logic ops on WIDTH-bit
//   operands, LANES result bits per RUN cycle, with valid/ready handshakes.
//   Parameters: WIDTH (>=1), LANES (WIDTH % LANES == 0).
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      synchronous active-high reset
//     in_valid   in   1      operand transfer request
//     in_ready   out  1      high only in IDLE
//     a, b       in   WIDTH  operands (b unused for NOT/BUF)
//     op         in   3      operation code
//     out_valid  out  1      result available (DONE)
//     out_ready  in   1      consumer accepts result
//     y          out  WIDTH  result register
//     busy       out  1      high in RUN or DONE
//     out_parity out  1      ^y, only when DEMUX_LOGIC_PARITY_EN is defined
import demux_gate_pkg::*;

module demux_logic_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
`ifdef DEMUX_LOGIC_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_param_check
    $error("demux_logic_engine: WIDTH must be >=1 and a multiple of LANES");
  end

  localparam int unsigned NCHUNK = WIDTH / LANES;
  localparam int unsigned CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    count_q, count_d;
  logic [LANES-1:0] a_chunk, b_chunk, y_chunk;
  logic             accept, last_chunk;
`ifdef DEMUX_LOGIC_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign accept     = in_valid && in_ready;
  assign last_chunk = (count_q == LAST_CNT);

  // Operand chunk selected by the current count.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      if (count_q == CW'(c)) begin
        a_chunk = a_q[c*LANES +: LANES];
        b_chunk = b_q[c*LANES +: LANES];
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_gate_slice u_slice (
      .a_i (a_chunk[i]),
      .b_i (b_chunk[i]),
      .op  (op_q),
      .y_o (y_chunk[i])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused code 3 falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)                 state_d = ST_RUN;
      ST_RUN:  if (last_chunk)             state_d = ST_DONE;
      ST_DONE: if (out_valid && out_ready) state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  end

  // Datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    count_d = count_q;
`ifdef DEMUX_LOGIC_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          y_d     = '0;
          count_d = '0;
`ifdef DEMUX_LOGIC_PARITY_EN
          parity_d = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        for (int unsigned c = 0; c < NCHUNK; c++) begin
          if (count_q == CW'(c)) begin
            y_d[c*LANES +: LANES] = y_chunk;
          end
        end
        count_d = count_q + 1'b1;
`ifdef DEMUX_LOGIC_PARITY_EN
        // Parity of the completed result, captured with the final chunk.
        if (last_chunk) begin
          parity_d = ^y_d;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      count_q <= '0;
`ifdef DEMUX_LOGIC_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      count_q <= count_d;
`ifdef DEMUX_LOGIC_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign y = y_q;
`ifdef DEMUX_LOGIC_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_demux_logic_engine.sv
// tb_demux_logic_engine
//   Directed bench for demux_logic_engine (WIDTH=8, LANES=2). Inputs are driven
//   and outputs sampled 1ns after each rising edge.
module tb_demux_logic_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, y;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef DEMUX_LOGIC_PARITY_EN
  logic       out_parity;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  demux_logic_engine #(.WIDTH(8), .LANES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
`ifdef DEMUX_LOGIC_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_model(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
    case (o)
      3'd0: return av & bv;
      3'd1: return av | bv;
      3'd2: return ~av;
      3'd3: return ~(av & bv);
      3'd4: return ~(av | bv);
      3'd5: return av ^ bv;
      3'd6: return ~(av ^ bv);
      default: return av;
    endcase
  endfunction

  // Presents one operand set in IDLE and waits (bounded) for out_valid.
  // Returns with the engine in DONE, 1ns after the edge that raised out_valid.
  task automatic txn(input string tag, input logic [2:0] o, input logic [7:0] av,
                     input logic [7:0] bv, input logic [7:0] ev);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    op = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom());
    b = 8'($urandom());
    op = 3'($urandom());
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check({tag, "_partial"}, 32'(y), 32'(ev & 8'h03));
      if (out_valid) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_y"}, 32'(y), 32'(ev));
`ifdef DEMUX_LOGIC_PARITY_EN
    check({tag, "_parity"}, 32'(out_parity), 32'(^ev));
`endif
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_ov_low"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] av, bv;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    out_ready = 1'b1;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_y", 32'(y), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 2. AND with immediate consumption
    txn("and", 3'd0, 8'hF0, 8'hAA, 8'hA0);
    check("and_busy", 32'(busy), 32'd1);
    drain("and");
    check("and_busy_idle", 32'(busy), 32'd0);

    // 3. XOR under back-pressure with an ignored concurrent request
    out_ready = 1'b0;
    txn("xor", 3'd5, 8'hFF, 8'h0F, 8'hF0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 8'h12;
      b = 8'h34;
      op = 3'd1;
      @(posedge clk); #1;
      check("bp_y", 32'(y), 32'hF0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    drain("xor");
    check("bp_y_kept", 32'(y), 32'hF0);
    check("bp_not_started", 32'(busy), 32'd0);

    // 4. NOT ignores b; BUF passes a
    txn("not", 3'd2, 8'h5A, 8'hFF, 8'hA5);
    drain("not");
    txn("buf", 3'd7, 8'h3C, 8'h00, 8'h3C);
    drain("buf");
    txn("buf1", 3'd7, 8'h01, 8'hFF, 8'h01);
    drain("buf1");

    // 5. reset in the second RUN cycle aborts
    in_valid = 1'b1;
    a = 8'h0F;
    b = 8'h33;
    op = 3'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_y", 32'(y), 32'h00);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // 6. all ops against the reference model
    for (int o = 0; o < 8; o++) begin
      for (int k = 0; k < 3; k++) begin
        av = 8'($urandom());
        bv = 8'($urandom());
        txn($sformatf("sweep_op%0d", o), 3'(o), av, bv, ref_model(3'(o), av, bv));
        drain($sformatf("sweep_op%0d", o));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
